pwm_capture: RTL and testbench

PWM receiver/decoder. It samples an asynchronous PWM input, measures the period and high time in clk cycles, and publishes each coherent period/high pair with a one-cycle valid strobe. It sits at the far end of a PWM link, used for loopback checking of the team's PWM generator and for decoding external PWM sensors. It also flags a stalled input (0% or 100% duty, or a disconnected wire) via a programmable timeout.

---
 rtl/pwm_capture.sv | 100 ++++++++++
 tb/tb_pwm_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: synchronises pwm_in, measures period/high time between rising edges,
// publishes each pair with a one-cycle strobe and flags a stalled input after a timeout.
module pwm_capture #(
  parameter int PWM_SIZE    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [PWM_SIZE-1:0] timeout_cycles,
  output logic [PWM_SIZE-1:0] meas_period,
  output logic [PWM_SIZE-1:0] meas_high,
  output logic                meas_valid,
  output logic                stuck,
  output logic                stuck_level
);

  typedef enum logic [1:0] {WAIT_RISE, MEASURE, STALL} state_t;

  localparam logic [PWM_SIZE-1:0] ALL_ONES = '1;
  localparam logic [PWM_SIZE-1:0] ONE      = PWM_SIZE'(1);

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s, s_d, rise, fall;
  logic [PWM_SIZE-1:0]     per_cnt, hi_cnt, hi_lat, lim;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign lim  = (timeout_cycles == '0) ? ALL_ONES : timeout_cycles;

  // Synchroniser runs regardless of enable so edge detection is valid on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_RISE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      hi_lat      <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else if (!enable) begin
      state      <= WAIT_RISE;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Counters saturate so a dead input can never wrap back into a plausible period.
      if (rise) begin
        per_cnt <= ONE;
        hi_cnt  <= ONE;
      end else begin
        if (per_cnt != ALL_ONES) per_cnt <= per_cnt + ONE;
        if (s && hi_cnt != ALL_ONES) hi_cnt <= hi_cnt + ONE;
      end
      if (fall) hi_lat <= hi_cnt;

      case (state)
        WAIT_RISE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            meas_period <= per_cnt;
            meas_high   <= hi_lat;
            meas_valid  <= 1'b1;
          end else if (per_cnt == lim) begin
            state       <= STALL;
            stuck       <= 1'b1;
            stuck_level <= s;
          end
        end
        STALL: begin
          // The stalled interval is not a real period, so nothing is published here.
          if (rise) begin
            state <= MEASURE;
            stuck <= 1'b0;
          end
        end
        default: state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM streams plus hand sequences
// for stall, reset and enable corner cases; expected measurements flow through a queue.
module tb_pwm_capture;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] timeout_cycles;
  logic [W-1:0] meas_period;
  logic [W-1:0] meas_high;
  logic         meas_valid;
  logic         stuck;
  logic         stuck_level;

  pwm_capture #(.PWM_SIZE(W), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .pwm_in         (pwm_in),
    .timeout_cycles (timeout_cycles),
    .meas_period    (meas_period),
    .meas_high      (meas_high),
    .meas_valid     (meas_valid),
    .stuck          (stuck),
    .stuck_level    (stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } exp_t;

  typedef struct {
    int period;
    int high;
    int reps;
    int exp_period;
    int exp_high;
  } vec_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           armed  = 1'b0;
  int           prev_p = 0;
  int           prev_h = 0;
  logic [W-1:0] last_p = '0;
  logic [W-1:0] last_h = '0;
  logic         prev_vld = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A rising edge completes the previous period; it is published only once armed.
  task automatic drive_rise();
    exp_t e;
    if (armed) begin
      e.p = W'(prev_p);
      e.h = W'(prev_h);
      exp_q.push_back(e);
    end
    armed  = 1'b1;
    pwm_in = 1'b1;
    tick();
  endtask

  task automatic pulse(input int p, input int h);
    drive_rise();
    repeat (h - 1) tick();
    pwm_in = 1'b0;
    repeat (p - h) tick();
    prev_p = p;
    prev_h = h;
  endtask

  // Output monitor: every strobe must match the oldest expected measurement.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (meas_valid) begin
        check("strobe_not_back_to_back", W'(prev_vld), '0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got period %0d high %0d, expected no strobe", meas_period, meas_high);
        end else begin
          e = exp_q.pop_front();
          check("meas_period", meas_period, e.p);
          check("meas_high", meas_high, e.h);
          last_p = e.p;
          last_h = e.h;
        end
      end
      prev_vld = meas_valid;
    end else begin
      prev_vld = 1'b0;
    end
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{period: 10, high: 3,  reps: 4, exp_period: 10, exp_high: 3};
    vecs[1] = '{period: 5,  high: 1,  reps: 4, exp_period: 5,  exp_high: 1};
    vecs[2] = '{period: 2,  high: 1,  reps: 4, exp_period: 2,  exp_high: 1};
    vecs[3] = '{period: 13, high: 12, reps: 3, exp_period: 13, exp_high: 12};
    vecs[4] = '{period: 10, high: 3,  reps: 2, exp_period: 10, exp_high: 3};

    rst_n          = 1'b0;
    enable         = 1'b1;
    pwm_in         = 1'b0;
    timeout_cycles = '0;
    #1;
    check("reset_period", meas_period, '0);
    check("reset_high", meas_high, '0);
    check("reset_valid", W'(meas_valid), '0);
    check("reset_stuck", W'(stuck), '0);
    check("reset_stuck_level", W'(stuck_level), '0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Continuous stream across table entries, including the 10/3 -> 5/1 change.
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive_rise_wrap(vecs[i].period, vecs[i].high, vecs[i].exp_period, vecs[i].exp_high);
      end
    end

    // Rise coinciding with the limit: the rise wins, no stall.
    timeout_cycles = W'(10);
    repeat (3) pulse(10, 3);
    check("limit_tie_no_stall", W'(stuck), '0);
    timeout_cycles = W'(50);

    // Held low after a fall: stuck exactly when per_cnt reaches 50.
    drive_rise();
    repeat (2) tick();
    pwm_in = 1'b0;
    repeat (49) tick();
    check("stall_low_not_early", W'(stuck), '0);
    tick();
    check("stall_low_stuck", W'(stuck), W'(1));
    check("stall_low_level", W'(stuck_level), '0);
    armed = 1'b0;
    repeat (5) tick();
    pulse(10, 3);
    check("stall_cleared_by_rise", W'(stuck), '0);
    pulse(10, 3);

    // Held high: stuck with level 1 and measurements untouched.
    drive_rise();
    repeat (51) tick();
    check("stall_high_not_early", W'(stuck), '0);
    tick();
    check("stall_high_stuck", W'(stuck), W'(1));
    check("stall_high_level", W'(stuck_level), W'(1));
    check("stall_high_hold_period", meas_period, last_p);
    check("stall_high_hold_high", meas_high, last_h);
    pwm_in = 1'b0;
    armed  = 1'b0;
    repeat (5) tick();

    // Asynchronous reset mid-period clears everything at once.
    timeout_cycles = '0;
    pulse(10, 3);
    pulse(8, 2);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_period", meas_period, '0);
    check("arst_high", meas_high, '0);
    check("arst_valid", W'(meas_valid), '0);
    check("arst_stuck", W'(stuck), '0);
    last_p = '0;
    last_h = '0;
    armed  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse(10, 3);
    check("arst_no_early_strobe", meas_period, '0);
    pulse(10, 3);
    pulse(10, 3);

    // Enable dropped while stalled: stuck clears, results hold, restart from WAIT_RISE.
    timeout_cycles = W'(20);
    repeat (25) tick();
    check("pre_disable_stuck", W'(stuck), W'(1));
    enable = 1'b0;
    tick();
    check("disable_stuck", W'(stuck), '0);
    check("disable_valid", W'(meas_valid), '0);
    repeat (6) tick();
    check("disable_hold_period", meas_period, last_p);
    check("disable_hold_high", meas_high, last_h);
    enable         = 1'b1;
    armed          = 1'b0;
    timeout_cycles = '0;
    tick();
    repeat (3) pulse(5, 2);
    repeat (6) tick();

    check("all_strobes_seen", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Table-row wrapper: the expected fields of each row feed the scoreboard.
  task automatic drive_rise_wrap(input int p, input int h, input int ep, input int eh);
    pulse(p, h);
    prev_p = ep;
    prev_h = eh;
  endtask

endmodule
